// File: rtl/rw_split_reg_pkg.sv
// Shared constants for the read/write split register.
// The toggle value selects the channel that receives the next accepted word.
package rw_split_reg_pkg;
   localparam int WIDTH_DEFAULT = 16;
   localparam logic CH1 = 1'b0;
   localparam logic CH2 = 1'b1;
endpackage

// File: rtl/rw_slot.sv
// Single-entry holding register with valid flag.
// Load wins over take, so a same-cycle take and refill keeps the slot full.
module rw_slot #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             take,
   input  logic [WIDTH-1:0] in_data,
   output logic [WIDTH-1:0] data,
   output logic             valid
);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         data  <= '0;
         valid <= 1'b0;
      end else if (load) begin
         data  <= in_data;
         valid <= 1'b1;
      end else if (take) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/rw_split_reg.sv
// Alternates accepted words between two output slots, even words to channel 1
// and odd words to channel 2. A stalled target slot blocks the input.
module rw_split_reg
   import rw_split_reg_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] read_1,
   output logic             read_1_valid,
   input  logic             read_1_ready,
   output logic [WIDTH-1:0] read_2,
   output logic             read_2_valid,
   input  logic             read_2_ready,
   output logic             toggle,
   output logic [7:0]       count
);

   logic accept;
   logic load_1;
   logic load_2;
   logic take_1;
   logic take_2;

   // The target slot can accept when empty or being drained this same cycle.
   assign in_ready = (toggle == CH1) ? (!read_1_valid || read_1_ready)
                                     : (!read_2_valid || read_2_ready);
   assign accept   = in_valid && in_ready;
   assign load_1   = accept && (toggle == CH1);
   assign load_2   = accept && (toggle == CH2);
   assign take_1   = read_1_valid && read_1_ready;
   assign take_2   = read_2_valid && read_2_ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         toggle <= CH1;
         count  <= 8'd0;
      end else if (accept) begin
         toggle <= ~toggle;
         count  <= count + 8'd1;
      end
   end

   rw_slot #(.WIDTH(WIDTH)) u_slot_1 (
      .clk     (clk),
      .rst     (rst),
      .load    (load_1),
      .take    (take_1),
      .in_data (in_data),
      .data    (read_1),
      .valid   (read_1_valid)
   );

   rw_slot #(.WIDTH(WIDTH)) u_slot_2 (
      .clk     (clk),
      .rst     (rst),
      .load    (load_2),
      .take    (take_2),
      .in_data (in_data),
      .data    (read_2),
      .valid   (read_2_valid)
   );

endmodule

// File: tb/tb_rw_split_reg.sv
// Directed bench for rw_split_reg: reset, alternation, stall, zero-bubble
// refill, counter wrap and asynchronous mid-run reset.
module tb_rw_split_reg;
   localparam int W = 16;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [W-1:0] in_data = '0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] read_1;
   logic         read_1_valid;
   logic         read_1_ready = 1'b0;
   logic [W-1:0] read_2;
   logic         read_2_valid;
   logic         read_2_ready = 1'b0;
   logic         toggle;
   logic [7:0]   count;

   int vectors = 0;
   int miscompares = 0;

   rw_split_reg #(.WIDTH(W)) dut (
      .clk          (clk),
      .rst          (rst),
      .in_data      (in_data),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .read_1       (read_1),
      .read_1_valid (read_1_valid),
      .read_1_ready (read_1_ready),
      .read_2       (read_2),
      .read_2_valid (read_2_valid),
      .read_2_ready (read_2_ready),
      .toggle       (toggle),
      .count        (count)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #1 rst = 1'b0;
      #1;
      vectors++; if (read_1 !== 16'h0) begin miscompares++; $display("FAIL rst_read_1 got %h want 0000", read_1); end
      vectors++; if (read_2 !== 16'h0) begin miscompares++; $display("FAIL rst_read_2 got %h want 0000", read_2); end
      vectors++; if ({read_1_valid, read_2_valid} !== 2'b00) begin miscompares++; $display("FAIL rst_valids got %b want 00", {read_1_valid, read_2_valid}); end
      vectors++; if (toggle !== 1'b0) begin miscompares++; $display("FAIL rst_toggle got %b want 0", toggle); end
      vectors++; if (count !== 8'h00) begin miscompares++; $display("FAIL rst_count got %h want 00", count); end
      vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
      in_valid = 1'b1; in_data = 16'h7777;
      tick();
      vectors++; if (count !== 8'h00 || read_1_valid !== 1'b0) begin miscompares++; $display("FAIL rst_no_accept count %h v1 %b want 00 0", count, read_1_valid); end
      in_valid = 1'b0;
      rst = 1'b1;
   endtask

   task automatic test_alternate();
      read_1_ready = 1'b1; read_2_ready = 1'b1;
      in_valid = 1'b1; in_data = 16'h1111;
      #1;
      vectors++; if (toggle !== 1'b0 || in_ready !== 1'b1) begin miscompares++; $display("FAIL alt_pre toggle %b rdy %b want 0 1", toggle, in_ready); end
      tick();
      vectors++; if (read_1 !== 16'h1111 || read_1_valid !== 1'b1) begin miscompares++; $display("FAIL alt_w0 read_1 %h v %b want 1111 1", read_1, read_1_valid); end
      vectors++; if (toggle !== 1'b1 || count !== 8'd1) begin miscompares++; $display("FAIL alt_w0_ctl toggle %b count %h want 1 01", toggle, count); end
      in_data = 16'h2222;
      tick();
      vectors++; if (read_2 !== 16'h2222 || read_2_valid !== 1'b1) begin miscompares++; $display("FAIL alt_w1 read_2 %h v %b want 2222 1", read_2, read_2_valid); end
      vectors++; if (toggle !== 1'b0 || count !== 8'd2) begin miscompares++; $display("FAIL alt_w1_ctl toggle %b count %h want 0 02", toggle, count); end
      vectors++; if (read_1_valid !== 1'b0 || read_1 !== 16'h1111) begin miscompares++; $display("FAIL alt_drain1 v %b data %h want 0 1111", read_1_valid, read_1); end
      in_valid = 1'b0;
      tick();
      vectors++; if (read_2_valid !== 1'b0 || count !== 8'd2 || toggle !== 1'b0) begin miscompares++; $display("FAIL alt_idle v2 %b count %h tog %b want 0 02 0", read_2_valid, count, toggle); end
   endtask

   task automatic test_stall();
      read_1_ready = 1'b0; read_2_ready = 1'b0;
      in_valid = 1'b1; in_data = 16'hAAAA;
      tick();
      in_data = 16'hBBBB;
      tick();
      vectors++; if (read_1 !== 16'hAAAA || read_2 !== 16'hBBBB) begin miscompares++; $display("FAIL stall_load r1 %h r2 %h want aaaa bbbb", read_1, read_2); end
      in_data = 16'hCCCC;
      #1;
      vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL stall_block in_ready %b want 0", in_ready); end
      tick();
      tick();
      vectors++; if (read_1 !== 16'hAAAA || read_1_valid !== 1'b1 || count !== 8'd4 || toggle !== 1'b0) begin miscompares++; $display("FAIL stall_hold r1 %h v %b cnt %h tog %b want aaaa 1 04 0", read_1, read_1_valid, count, toggle); end
      read_1_ready = 1'b1;
      #1;
      vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL stall_release in_ready %b want 1", in_ready); end
      tick();
      vectors++; if (read_1 !== 16'hCCCC || read_1_valid !== 1'b1 || count !== 8'd5 || toggle !== 1'b1) begin miscompares++; $display("FAIL stall_refill r1 %h v %b cnt %h tog %b want cccc 1 05 1", read_1, read_1_valid, count, toggle); end
      in_valid = 1'b0; read_2_ready = 1'b1;
      tick();
      vectors++; if ({read_1_valid, read_2_valid} !== 2'b00 || count !== 8'd5) begin miscompares++; $display("FAIL stall_both_drain v %b cnt %h want 00 05", {read_1_valid, read_2_valid}, count); end
   endtask

   task automatic test_back_to_back();
      // toggle is 1 here: word 0x0002 realigns to channel 1
      in_valid = 1'b1; in_data = 16'h0002;
      tick();
      read_1_ready = 1'b0; in_data = 16'h0001;
      tick();
      in_data = 16'h0002;
      tick();
      vectors++; if (read_1 !== 16'h0001 || read_1_valid !== 1'b1 || toggle !== 1'b0) begin miscompares++; $display("FAIL b2b_setup r1 %h v %b tog %b want 0001 1 0", read_1, read_1_valid, toggle); end
      read_1_ready = 1'b1; in_data = 16'h0003;
      tick();
      vectors++; if (read_1 !== 16'h0003 || read_1_valid !== 1'b1) begin miscompares++; $display("FAIL b2b_refill r1 %h v %b want 0003 1", read_1, read_1_valid); end
      vectors++; if (count !== 8'd9 || toggle !== 1'b1) begin miscompares++; $display("FAIL b2b_ctl cnt %h tog %b want 09 1", count, toggle); end
      in_valid = 1'b0;
      tick();
   endtask

   task automatic test_wrap();
      #1 rst = 1'b0;
      #1 rst = 1'b1;
      read_1_ready = 1'b1; read_2_ready = 1'b1; in_valid = 1'b1;
      for (int i = 0; i < 256; i++) begin
         in_data = 16'(i);
         tick();
         if (i == 254) begin
            vectors++; if (count !== 8'hFF) begin miscompares++; $display("FAIL wrap_255 cnt %h want ff", count); end
         end
      end
      vectors++; if (count !== 8'h00 || toggle !== 1'b0) begin miscompares++; $display("FAIL wrap_ctl cnt %h tog %b want 00 0", count, toggle); end
      vectors++; if (read_2 !== 16'h00FF || read_2_valid !== 1'b1 || read_1 !== 16'h00FE) begin miscompares++; $display("FAIL wrap_data r2 %h v %b r1 %h want 00ff 1 00fe", read_2, read_2_valid, read_1); end
   endtask

   task automatic test_async_reset();
      read_1_ready = 1'b0; read_2_ready = 1'b0;
      in_data = 16'h1234;
      tick();
      in_valid = 1'b0;
      vectors++; if ({read_1_valid, read_2_valid} !== 2'b11 || read_1 !== 16'h1234) begin miscompares++; $display("FAIL ar_full v %b r1 %h want 11 1234", {read_1_valid, read_2_valid}, read_1); end
      #2 rst = 1'b0;
      #1;
      vectors++; if (read_1 !== 16'h0 || read_2 !== 16'h0 || {read_1_valid, read_2_valid} !== 2'b00) begin miscompares++; $display("FAIL ar_clear r1 %h r2 %h v %b want 0000 0000 00", read_1, read_2, {read_1_valid, read_2_valid}); end
      vectors++; if (toggle !== 1'b0 || count !== 8'h00 || in_ready !== 1'b1) begin miscompares++; $display("FAIL ar_ctl tog %b cnt %h rdy %b want 0 00 1", toggle, count, in_ready); end
      @(negedge clk);
      rst = 1'b1;
      in_valid = 1'b1; in_data = 16'h5A5A;
      tick();
      in_valid = 1'b0;
      vectors++; if (read_1 !== 16'h5A5A || read_1_valid !== 1'b1 || read_2_valid !== 1'b0) begin miscompares++; $display("FAIL ar_first r1 %h v1 %b v2 %b want 5a5a 1 0", read_1, read_1_valid, read_2_valid); end
      vectors++; if (toggle !== 1'b1 || count !== 8'd1) begin miscompares++; $display("FAIL ar_first_ctl tog %b cnt %h want 1 01", toggle, count); end
   endtask

   initial begin
      test_reset();
      test_alternate();
      test_stall();
      test_back_to_back();
      test_wrap();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout reached at %0t", $time);
      $fatal(1);
   end

endmodule
